// File: rtl/gpio_seq.sv
// GPIO output pattern sequencer: plays a table of {value, hold} entries as bus writes to the GPIO ODR.
// Latency: m_req rises the cycle after start; successive writes are delay+2 cycles apart with immediate gnt/rvalid.
// Backpressure: m_req/m_addr/m_wdata held stable until m_gnt; sequencing stalls in WAIT until m_rvalid.
module gpio_seq #(
  parameter int          DEPTH      = 16,
  parameter logic [31:0] GPIO_BASE  = 32'h0000_0000,
  parameter logic [11:0] ODR_OFFSET = 12'h008
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     cfg_we,
  input  logic [$clog2(DEPTH)-1:0] cfg_waddr,
  input  logic [31:0]              cfg_value,
  input  logic [15:0]              cfg_delay,
  input  logic [$clog2(DEPTH)-1:0] last_idx,
  input  logic                     loop_en,
  input  logic                     start,
  input  logic                     stop,
  output logic                     busy,
  output logic                     done,
  output logic [$clog2(DEPTH)-1:0] cur_idx,
  output logic                     m_req,
  input  logic                     m_gnt,
  input  logic                     m_rvalid,
  output logic [31:0]              m_addr,
  output logic                     m_we,
  output logic [3:0]               m_be,
  output logic [31:0]              m_wdata
);

  localparam int IW = $clog2(DEPTH);

  typedef struct packed {
    logic [31:0] value;
    logic [15:0] delay;
  } entry_t;

  typedef enum logic [1:0] {S_IDLE, S_REQ, S_WAIT, S_DELAY} state_t;

  state_t          state;
  entry_t          tbl [DEPTH];
  logic [15:0]     cnt;
  logic            stop_pend;
  logic            at_last;
  logic            nxt_end;
  logic [IW-1:0]   nxt_idx;

  assign m_addr  = GPIO_BASE + {20'h0, ODR_OFFSET};
  assign m_we    = 1'b1;
  assign m_be    = 4'hF;
  assign m_wdata = tbl[cur_idx].value;

  // Decision taken when an entry's hold time ends; loop controls are sampled live.
  always_comb begin
    at_last = (cur_idx == last_idx);
    nxt_end = at_last && !loop_en;
    nxt_idx = at_last ? '0 : cur_idx + IW'(1);
  end

  // Table storage and sequencer FSM with registered outputs.
  always_ff @(posedge clk) begin
    if (rst) begin
      state     <= S_IDLE;
      busy      <= 1'b0;
      done      <= 1'b0;
      cur_idx   <= '0;
      m_req     <= 1'b0;
      cnt       <= '0;
      stop_pend <= 1'b0;
      for (int i = 0; i < DEPTH; i++) tbl[i] <= '0;
    end else begin
      done <= 1'b0;
      if (cfg_we && state == S_IDLE) tbl[cfg_waddr] <= '{value: cfg_value, delay: cfg_delay};
      case (state)
        S_IDLE: begin
          if (start && !stop) begin
            state   <= S_REQ;
            busy    <= 1'b1;
            m_req   <= 1'b1;
            cur_idx <= '0;
          end
        end
        S_REQ: begin
          if (stop) stop_pend <= 1'b1;
          if (m_gnt) begin
            state <= S_WAIT;
            m_req <= 1'b0;
          end
        end
        S_WAIT: begin
          if (m_rvalid) begin
            if (stop_pend || stop) begin
              state     <= S_IDLE;
              busy      <= 1'b0;
              stop_pend <= 1'b0;
            end else if (tbl[cur_idx].delay == 16'd0) begin
              if (nxt_end) begin
                state <= S_IDLE;
                busy  <= 1'b0;
                done  <= 1'b1;
              end else begin
                state   <= S_REQ;
                m_req   <= 1'b1;
                cur_idx <= nxt_idx;
              end
            end else begin
              cnt   <= tbl[cur_idx].delay;
              state <= S_DELAY;
            end
          end else if (stop) begin
            stop_pend <= 1'b1;
          end
        end
        S_DELAY: begin
          if (stop) begin
            state     <= S_IDLE;
            busy      <= 1'b0;
            stop_pend <= 1'b0;
          end else if (cnt == 16'd1) begin
            if (nxt_end) begin
              state <= S_IDLE;
              busy  <= 1'b0;
              done  <= 1'b1;
            end else begin
              state   <= S_REQ;
              m_req   <= 1'b1;
              cur_idx <= nxt_idx;
            end
          end else begin
            cnt <= cnt - 16'd1;
          end
        end
        default: begin
          state <= S_IDLE;
          busy  <= 1'b0;
          m_req <= 1'b0;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_gpio_seq.sv
// Directed bench for gpio_seq with a simple bus responder (programmable gnt wait, rvalid one cycle after gnt).
// Inputs and checks happen 1 time unit after the rising edge; the responder drives at 2 units after.
// Each scenario task compares observed outputs against hand-computed expectations.
module tb_gpio_seq;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        cfg_we = 1'b0;
  logic [3:0]  cfg_waddr = '0;
  logic [31:0] cfg_value = '0;
  logic [15:0] cfg_delay = '0;
  logic [3:0]  last_idx = '0;
  logic        loop_en = 1'b0;
  logic        start = 1'b0;
  logic        stop = 1'b0;
  logic        busy, done, m_req, m_we;
  logic [3:0]  cur_idx, m_be;
  logic        m_gnt = 1'b0;
  logic        m_rvalid = 1'b0;
  logic [31:0] m_addr, m_wdata;

  int checks = 0;
  int errors = 0;
  int cyc = 0;
  int gnt_delay = 0;
  int rsp_cnt = 0;
  logic rsp_pend = 1'b0;

  int req_cyc[$];
  logic [31:0] req_dat[$];
  logic [31:0] req_adr[$];
  int done_cyc[$];
  logic done_busy[$];
  logic cap_to;

  gpio_seq dut (
    .clk(clk), .rst(rst), .cfg_we(cfg_we), .cfg_waddr(cfg_waddr), .cfg_value(cfg_value),
    .cfg_delay(cfg_delay), .last_idx(last_idx), .loop_en(loop_en), .start(start), .stop(stop),
    .busy(busy), .done(done), .cur_idx(cur_idx), .m_req(m_req), .m_gnt(m_gnt),
    .m_rvalid(m_rvalid), .m_addr(m_addr), .m_we(m_we), .m_be(m_be), .m_wdata(m_wdata)
  );

  always #5 clk = ~clk;

  always @(posedge clk) cyc = cyc + 1;

  // Bus slave: grant after gnt_delay waiting cycles, respond one cycle after the grant.
  always @(posedge clk) begin
    #2;
    if (rst) begin
      m_gnt = 1'b0; m_rvalid = 1'b0; rsp_pend = 1'b0; rsp_cnt = 0;
    end else begin
      m_rvalid = rsp_pend;
      rsp_pend = 1'b0;
      m_gnt = 1'b0;
      if (m_req) begin
        if (rsp_cnt >= gnt_delay) begin
          m_gnt = 1'b1; rsp_pend = 1'b1; rsp_cnt = 0;
        end else begin
          rsp_cnt = rsp_cnt + 1;
        end
      end
    end
  end

  initial begin
    #400000;
    $display("FAIL watchdog: simulation did not complete within time limit");
    $fatal(1, "watchdog expired");
  end

  task automatic tick();
    @(posedge clk); #1;
  endtask

  task automatic write_entry(input logic [3:0] idx, input logic [31:0] val, input logic [15:0] dly);
    cfg_we = 1'b1; cfg_waddr = idx; cfg_value = val; cfg_delay = dly;
    tick();
    cfg_we = 1'b0;
  endtask

  task automatic pulse_start();
    start = 1'b1;
    tick();
    start = 1'b0;
  endtask

  // Records write and done events until the sequencer goes idle (plus a short tail).
  task automatic capture(input int maxc);
    logic prev;
    int tail;
    req_cyc.delete(); req_dat.delete(); req_adr.delete();
    done_cyc.delete(); done_busy.delete();
    cap_to = 1'b1; prev = 1'b0; tail = -1;
    for (int i = 0; i < maxc && tail != 0; i++) begin
      if (m_req && !prev) begin
        req_cyc.push_back(cyc); req_dat.push_back(m_wdata); req_adr.push_back(m_addr);
      end
      prev = m_req;
      if (done) begin done_cyc.push_back(cyc); done_busy.push_back(busy); end
      if (tail > 0) tail--;
      else if (tail < 0 && !busy) begin cap_to = 1'b0; tail = 3; end
      tick();
    end
  endtask

  task automatic wait_idle(input int maxc, output logic ok);
    ok = 1'b0;
    for (int i = 0; i < maxc && !ok; i++) begin
      if (!busy) ok = 1'b1;
      else tick();
    end
  endtask

  task automatic test_reset();
    rst = 1'b1; tick(); tick(); rst = 1'b0;
    checks++; if (busy !== 1'b0) begin errors++; $display("FAIL reset_busy: got %b want 0", busy); end
    checks++; if (done !== 1'b0) begin errors++; $display("FAIL reset_done: got %b want 0", done); end
    checks++; if (cur_idx !== 4'd0) begin errors++; $display("FAIL reset_cur_idx: got %0d want 0", cur_idx); end
    checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL reset_m_req: got %b want 0", m_req); end
    checks++; if (m_wdata !== 32'h0) begin errors++; $display("FAIL reset_m_wdata: got %h want 0", m_wdata); end
    checks++; if (m_addr !== 32'h0000_0008) begin errors++; $display("FAIL const_m_addr: got %h want 00000008", m_addr); end
    checks++; if (m_we !== 1'b1 || m_be !== 4'hF) begin errors++; $display("FAIL const_we_be: got %b/%h want 1/f", m_we, m_be); end
  endtask

  task automatic test_single();
    gnt_delay = 0;
    write_entry(4'd0, 32'hA5A5_0001, 16'd3);
    last_idx = 4'd0; loop_en = 1'b0;
    pulse_start();
    checks++; if (m_req !== 1'b1 || busy !== 1'b1) begin errors++; $display("FAIL single_req_after_start: got req=%b busy=%b want 1/1", m_req, busy); end
    capture(60);
    checks++; if (cap_to !== 1'b0) begin errors++; $display("FAIL single_timeout: sequencer still busy, want idle"); end
    checks++; if (req_cyc.size() != 1) begin errors++; $display("FAIL single_nwrites: got %0d want 1", req_cyc.size()); end
    checks++; if (req_dat.size() > 0 && req_dat[0] !== 32'hA5A5_0001) begin errors++; $display("FAIL single_wdata: got %h want a5a50001", req_dat[0]); end
    checks++; if (done_cyc.size() != 1) begin errors++; $display("FAIL single_ndone: got %0d want 1", done_cyc.size()); end
    if (done_cyc.size() > 0 && req_cyc.size() > 0) begin
      checks++; if (done_cyc[0] - req_cyc[0] != 5) begin errors++; $display("FAIL single_done_latency: got %0d want 5", done_cyc[0] - req_cyc[0]); end
      checks++; if (done_busy[0] !== 1'b0) begin errors++; $display("FAIL single_busy_at_done: got %b want 0", done_busy[0]); end
    end
  endtask

  task automatic test_multi();
    logic [15:0] dl [4] = '{16'd0, 16'd1, 16'd2, 16'd5};
    int gap [3] = '{2, 3, 4};
    gnt_delay = 0;
    for (int i = 0; i < 4; i++) write_entry(4'(i), 32'h1111_0000 + 32'(i), dl[i]);
    last_idx = 4'd3; loop_en = 1'b0;
    pulse_start();
    capture(100);
    checks++; if (req_cyc.size() != 4) begin errors++; $display("FAIL multi_nwrites: got %0d want 4", req_cyc.size()); end
    if (req_cyc.size() == 4) begin
      for (int i = 0; i < 4; i++) begin
        checks++; if (req_dat[i] !== 32'h1111_0000 + 32'(i)) begin errors++; $display("FAIL multi_wdata%0d: got %h want %h", i, req_dat[i], 32'h1111_0000 + 32'(i)); end
      end
      for (int i = 0; i < 3; i++) begin
        checks++; if (req_cyc[i+1] - req_cyc[i] != gap[i]) begin errors++; $display("FAIL multi_gap%0d: got %0d want %0d", i, req_cyc[i+1] - req_cyc[i], gap[i]); end
      end
      checks++; if (done_cyc.size() != 1) begin errors++; $display("FAIL multi_ndone: got %0d want 1", done_cyc.size()); end
      else begin
        checks++; if (done_cyc[0] - req_cyc[3] != 7) begin errors++; $display("FAIL multi_done_latency: got %0d want 7", done_cyc[0] - req_cyc[3]); end
      end
    end
  endtask

  task automatic test_backpressure();
    logic ok;
    gnt_delay = 7;
    write_entry(4'd0, 32'hBEEF_0000, 16'd0);
    write_entry(4'd1, 32'hBEEF_0001, 16'd0);
    last_idx = 4'd1; loop_en = 1'b0;
    pulse_start();
    for (int i = 0; i < 8; i++) begin
      checks++; if (m_req !== 1'b1 || m_wdata !== 32'hBEEF_0000 || cur_idx !== 4'd0) begin
        errors++; $display("FAIL bp_hold%0d: got req=%b wdata=%h idx=%0d want 1/beef0000/0", i, m_req, m_wdata, cur_idx);
      end
      tick();
    end
    checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL bp_after_gnt: got req=%b want 0", m_req); end
    tick();
    checks++; if (m_req !== 1'b1 || m_wdata !== 32'hBEEF_0001 || cur_idx !== 4'd1) begin
      errors++; $display("FAIL bp_advance: got req=%b wdata=%h idx=%0d want 1/beef0001/1", m_req, m_wdata, cur_idx);
    end
    wait_idle(100, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL bp_timeout: busy=%b want 0", busy); end
    gnt_delay = 0;
  endtask

  task automatic test_loop_stop();
    int nreq = 0, ndone = 0, nextra = 0;
    logic prev = 1'b0, hit = 1'b0;
    gnt_delay = 1;
    write_entry(4'd0, 32'hC0DE_0000, 16'd1);
    write_entry(4'd1, 32'hC0DE_0001, 16'd1);
    last_idx = 4'd1; loop_en = 1'b1;
    pulse_start();
    for (int i = 0; i < 300 && !hit; i++) begin
      if (m_req && !prev) begin nreq++; if (nreq == 7) hit = 1'b1; end
      prev = m_req;
      if (done) ndone++;
      if (!hit) tick();
    end
    checks++; if (hit !== 1'b1) begin errors++; $display("FAIL loop_timeout: got %0d writes want 7", nreq); end
    checks++; if (ndone != 0) begin errors++; $display("FAIL loop_done_while_looping: got %0d want 0", ndone); end
    checks++; if (m_wdata !== 32'hC0DE_0000 || cur_idx !== 4'd0) begin errors++; $display("FAIL loop_wrap: got wdata=%h idx=%0d want c0de0000/0", m_wdata, cur_idx); end
    stop = 1'b1; tick(); stop = 1'b0;
    checks++; if (m_req !== 1'b1) begin errors++; $display("FAIL stop_req_held: got %b want 1", m_req); end
    tick();
    checks++; if (m_req !== 1'b0 || busy !== 1'b1) begin errors++; $display("FAIL stop_wait: got req=%b busy=%b want 0/1", m_req, busy); end
    tick();
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL stop_idle: got busy=%b done=%b want 0/0", busy, done); end
    for (int i = 0; i < 10; i++) begin
      if (m_req || done) nextra++;
      tick();
    end
    checks++; if (nextra != 0) begin errors++; $display("FAIL stop_quiet: got %0d active cycles want 0", nextra); end
    loop_en = 1'b0; gnt_delay = 0;
  endtask

  task automatic test_stop_delay();
    write_entry(4'd0, 32'h0000_0100, 16'd100);
    last_idx = 4'd0;
    pulse_start();
    tick(); tick(); tick(); tick();
    checks++; if (busy !== 1'b1) begin errors++; $display("FAIL delay_busy: got %b want 1", busy); end
    stop = 1'b1; tick(); stop = 1'b0;
    checks++; if (busy !== 1'b0 || done !== 1'b0) begin errors++; $display("FAIL delay_stop: got busy=%b done=%b want 0/0", busy, done); end
    start = 1'b1; stop = 1'b1; tick(); start = 1'b0; stop = 1'b0;
    checks++; if (m_req !== 1'b0 || busy !== 1'b0) begin errors++; $display("FAIL start_stop_same: got req=%b busy=%b want 0/0", m_req, busy); end
    tick();
    checks++; if (m_req !== 1'b0) begin errors++; $display("FAIL start_stop_later: got req=%b want 0", m_req); end
  endtask

  task automatic test_cfg_lock_reset();
    logic ok;
    write_entry(4'd0, 32'h1234_5678, 16'd10);
    last_idx = 4'd0; loop_en = 1'b0;
    pulse_start();
    write_entry(4'd0, 32'hDEAD_DEAD, 16'd1);
    wait_idle(100, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL lock_timeout: busy=%b want 0", busy); end
    tick();
    pulse_start();
    checks++; if (m_wdata !== 32'h1234_5678) begin errors++; $display("FAIL cfg_lockout: got %h want 12345678", m_wdata); end
    wait_idle(100, ok);
    gnt_delay = 5;
    write_entry(4'd1, 32'h5555_AAAA, 16'd0);
    last_idx = 4'd1;
    pulse_start();
    tick(); tick(); tick();
    checks++; if (m_req !== 1'b1) begin errors++; $display("FAIL rst_pre_req: got %b want 1", m_req); end
    rst = 1'b1; tick(); rst = 1'b0;
    checks++; if (m_req !== 1'b0 || cur_idx !== 4'd0 || busy !== 1'b0) begin
      errors++; $display("FAIL rst_midrun: got req=%b idx=%0d busy=%b want 0/0/0", m_req, cur_idx, busy);
    end
    checks++; if (m_wdata !== 32'h0) begin errors++; $display("FAIL rst_table_clear: got %h want 0", m_wdata); end
    gnt_delay = 0;
    pulse_start();
    tick();
    checks++; if (m_wdata !== 32'h0 || cur_idx !== 4'd0) begin errors++; $display("FAIL rst_cleared_entry: got %h idx=%0d want 0/0", m_wdata, cur_idx); end
    tick();
    checks++; if (m_req !== 1'b1 || m_wdata !== 32'h0 || cur_idx !== 4'd1) begin
      errors++; $display("FAIL rst_cleared_entry1: got req=%b wdata=%h idx=%0d want 1/0/1", m_req, m_wdata, cur_idx);
    end
    wait_idle(100, ok);
    checks++; if (ok !== 1'b1) begin errors++; $display("FAIL rst_rerun_timeout: busy=%b want 0", busy); end
  endtask

  initial begin
    #1;
    test_reset();
    test_single();
    test_multi();
    test_backpressure();
    test_loop_stop();
    test_stop_delay();
    test_cfg_lock_reset();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
